airi5c_float_cmp_unit: RTL and testbench
========================================

AIRI5C_FLOAT_CMP_UNIT -- requirements
Module: airi5c_float_cmp_unit

Purpose: sequential FPU back end for single-precision compare-class instructions. Turns operand ordering into architectural results: FEQ.S, FLT.S and FLE.S give an integer 0/1; FMIN.S and FMAX.S give a float. Also produces the RISC-V invalid flag and a load/ready handshake.

Interface
REQ-001 SHALL have no parameters.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 n_reset  input  1  asynchronous, active-low reset.
REQ-004 kill  input  1  abort current operation.
REQ-005 load  input  1  start operation; captures a, b, op this cycle.
REQ-006 op  input  3  000 FEQ, 001 FLT, 010 FLE, 011 FMIN, 100 FMAX; 101-111 reserved.
REQ-007 a  input  32  IEEE-754 binary32 operand rs1.
REQ-008 b  input  32  IEEE-754 binary32 operand rs2.
REQ-009 result  output  32  registered result; compare ops zero-extend 0/1 into bit 0.
REQ-010 IV  output  1  registered invalid-operation flag for the completed operation.
REQ-011 ready  output  1  registered completion strobe.

Function
REQ-012 SHALL implement FSM states IDLE, EXEC, DONE.
REQ-013 load in any state SHALL capture a, b, op into internal registers and go to EXEC; any in-flight operation is abandoned.
REQ-014 EXEC SHALL classify both operands and compute greater/equal/less/unordered on the captured values, register them, then go to DONE.
- Classification: zero, sNaN, qNaN.
- Ordering: +0 and -0 compare equal; any NaN gives unordered.
REQ-015 DONE SHALL update result and IV, assert ready for exactly one cycle, then go to IDLE.
- Latency: load at edge N gives ready=1 during cycle N+2.
REQ-016 result and IV SHALL hold their values until the next DONE; ready SHALL be 0 outside DONE.
REQ-017 FEQ: result = equal; IV = 1 only if either operand is an sNaN.
REQ-018 FLT: result = less; FLE: result = less or equal; for both, IV = 1 if either operand is any NaN.
REQ-019 FMIN/FMAX with neither operand NaN SHALL return the smaller/larger operand bit-exactly.
- Signed zeros are ordered -0 < +0 for selection only.
- Equal non-zero operands return a.
REQ-020 FMIN/FMAX with exactly one NaN operand SHALL return the other operand.
REQ-021 FMIN/FMAX with both operands NaN SHALL return canonical NaN 0x7FC00000.
REQ-022 FMIN/FMAX SHALL set IV = 1 only if either operand is an sNaN.
REQ-023 Reserved op SHALL complete with normal timing, result = 0x00000000, IV = 0.
REQ-024 kill SHALL force IDLE on the next edge with ready = 0, leaving result and IV unchanged.
REQ-025 kill and load in the same cycle: kill SHALL win and the load SHALL be discarded.
REQ-026 load asserted during DONE: the DONE outputs for the old operation SHALL still appear that cycle, and the new operation SHALL enter EXEC.
REQ-027 Operand inputs SHALL be sampled only on the load cycle; later changes on a/b/op SHALL NOT affect the result.

Reset
REQ-028 n_reset low SHALL immediately, without a clock edge, force the following:
- state IDLE;
- result = 0x00000000;
- IV = 0;
- ready = 0;
- captured operand and flag registers = 0.
REQ-029 Reset asserted mid-operation SHALL discard that operation; no ready pulse SHALL follow reset release without a new load.

Verification
REQ-030 FLT a=0xBF800000, b=0x3F800000, load at edge 0 -> ready=1 only in cycle 2, result=0x00000001, IV=0.
REQ-031 FEQ a=0x80000000, b=0x00000000 -> result=1, IV=0; FMIN same operands -> 0x80000000; FMAX -> 0x00000000.
REQ-032 FLE a=0x7FC00000, b=0x3F800000 -> result=0, IV=1; FEQ same operands -> result=0, IV=0.
REQ-033 FMAX a=0x7F800001, b=0x40000000 -> result=0x40000000, IV=1; FMIN a=0x7FC00000, b=0xFFC00000 -> 0x7FC00000, IV=0.
REQ-034 Complete FLT (result=1), then load FEQ 1.0 vs 2.0 and assert kill in EXEC -> no ready pulse, result stays 0x00000001; then load and kill together -> state IDLE, no ready.
REQ-035 Assert n_reset low asynchronously during EXEC -> outputs zero before the next edge; after release, no ready pulse until a fresh load.

Source files
------------

// File: rtl/airi5c_float_cmp_unit.sv
// airi5c_float_cmp_unit
// Sequential back end for the single-precision compare-class instructions
// FEQ.S, FLT.S, FLE.S, FMIN.S and FMAX.S. An operation is captured on load,
// classified and ordered in EXEC, and its result, invalid flag and a one-cycle
// ready strobe are registered while leaving DONE.
//
// Ports
//   clk      : clock, all state changes on the rising edge
//   n_reset  : asynchronous active-low reset
//   kill     : abort the current operation (wins over load)
//   load     : capture a, b, op and start a new operation
//   op       : 000 FEQ, 001 FLT, 010 FLE, 011 FMIN, 100 FMAX, others reserved
//   a, b     : binary32 operands rs1 / rs2
//   result   : registered result (compares give 0/1 in bit 0)
//   IV       : registered invalid-operation flag
//   ready    : registered completion strobe, high for one cycle
module airi5c_float_cmp_unit (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        kill,
  input  logic        load,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        IV,
  output logic        ready
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  localparam logic [31:0] CANONICAL_NAN = 32'h7FC00000;

  state_t      state_q, state_d;
  logic [31:0] opA_q, opB_q;
  logic [2:0]  opSel_q;
  logic        less_q, equal_q, greater_q, unord_q;
  logic        aNan_q, bNan_q, aSnan_q, bSnan_q, aZero_q, bZero_q;
  logic [31:0] result_q, result_d;
  logic        iv_q, iv_d;
  logic        ready_q, ready_d;

  logic        aNan, bNan, aSnan, bSnan, aZero, bZero, magLess;
  logic        lessD, equalD, greaterD, unordD;
  logic [31:0] cmpResult;
  logic        cmpIv, zeroTie;

  // State register.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic: kill beats load, and load restarts from any state.
  always_comb begin
    state_d = state_q;
    if (kill) begin
      state_d = IDLE;
    end else if (load) begin
      state_d = EXEC;
    end else begin
      case (state_q)
        EXEC:    state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Operand capture happens only on an accepted load.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      opA_q   <= '0;
      opB_q   <= '0;
      opSel_q <= '0;
    end else if (load && !kill) begin
      opA_q   <= a;
      opB_q   <= b;
      opSel_q <= op;
    end
  end

  // Classification and ordering of the captured operands. Both zeros compare
  // equal; with equal signs and different values, the magnitude comparison
  // flips for negative numbers.
  always_comb begin
    aNan    = (&opA_q[30:23]) && (|opA_q[22:0]);
    bNan    = (&opB_q[30:23]) && (|opB_q[22:0]);
    aSnan   = aNan && !opA_q[22];
    bSnan   = bNan && !opB_q[22];
    aZero   = ~|opA_q[30:0];
    bZero   = ~|opB_q[30:0];
    magLess = opA_q[30:0] < opB_q[30:0];
    unordD  = aNan || bNan;
    equalD  = !unordD && ((aZero && bZero) || (opA_q == opB_q));
    lessD   = 1'b0;
    if (!unordD && !equalD) begin
      if (opA_q[31] != opB_q[31]) lessD = opA_q[31];
      else if (opA_q[31])         lessD = !magLess;
      else                        lessD = magLess;
    end
    greaterD = !unordD && !equalD && !lessD;
  end

  // Ordering flags are registered at the end of EXEC.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      less_q    <= 1'b0;
      equal_q   <= 1'b0;
      greater_q <= 1'b0;
      unord_q   <= 1'b0;
      aNan_q    <= 1'b0;
      bNan_q    <= 1'b0;
      aSnan_q   <= 1'b0;
      bSnan_q   <= 1'b0;
      aZero_q   <= 1'b0;
      bZero_q   <= 1'b0;
    end else if (state_q == EXEC && !kill) begin
      less_q    <= lessD;
      equal_q   <= equalD;
      greater_q <= greaterD;
      unord_q   <= unordD;
      aNan_q    <= aNan;
      bNan_q    <= bNan;
      aSnan_q   <= aSnan;
      bSnan_q   <= bSnan;
      aZero_q   <= aZero;
      bZero_q   <= bZero;
    end
  end

  // Result selection from the registered flags. For a +0/-0 tie, FMIN takes
  // the negative zero and FMAX the positive one; other ties return a.
  always_comb begin
    zeroTie   = equal_q && aZero_q && bZero_q;
    cmpResult = '0;
    cmpIv     = 1'b0;
    case (opSel_q)
      3'd0: begin
        cmpResult = {31'b0, equal_q};
        cmpIv     = aSnan_q || bSnan_q;
      end
      3'd1: begin
        cmpResult = {31'b0, less_q};
        cmpIv     = unord_q;
      end
      3'd2: begin
        cmpResult = {31'b0, less_q || equal_q};
        cmpIv     = unord_q;
      end
      3'd3: begin
        if (aNan_q && bNan_q)            cmpResult = CANONICAL_NAN;
        else if (aNan_q)                 cmpResult = opB_q;
        else if (bNan_q)                 cmpResult = opA_q;
        else if (less_q)                 cmpResult = opA_q;
        else if (greater_q)              cmpResult = opB_q;
        else if (zeroTie && opB_q[31])   cmpResult = opB_q;
        else                             cmpResult = opA_q;
        cmpIv = aSnan_q || bSnan_q;
      end
      3'd4: begin
        if (aNan_q && bNan_q)            cmpResult = CANONICAL_NAN;
        else if (aNan_q)                 cmpResult = opB_q;
        else if (bNan_q)                 cmpResult = opA_q;
        else if (less_q)                 cmpResult = opB_q;
        else if (greater_q)              cmpResult = opA_q;
        else if (zeroTie && opA_q[31])   cmpResult = opB_q;
        else                             cmpResult = opA_q;
        cmpIv = aSnan_q || bSnan_q;
      end
      default: begin
        cmpResult = '0;
        cmpIv     = 1'b0;
      end
    endcase
  end

  // Output logic: outputs only change when DONE completes without a kill.
  always_comb begin
    result_d = result_q;
    iv_d     = iv_q;
    ready_d  = 1'b0;
    if (state_q == DONE && !kill) begin
      result_d = cmpResult;
      iv_d     = cmpIv;
      ready_d  = 1'b1;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      result_q <= '0;
      iv_q     <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      result_q <= result_d;
      iv_q     <= iv_d;
      ready_q  <= ready_d;
    end
  end

  assign result = result_q;
  assign IV     = iv_q;
  assign ready  = ready_q;

endmodule

// File: tb/tb_airi5c_float_cmp_unit.sv
// Testbench for airi5c_float_cmp_unit: directed vectors, randomized operations
// against a value-level reference model, back-to-back loads, kill handling and
// asynchronous reset.
module tb_airi5c_float_cmp_unit;

  logic        clk = 1'b0;
  logic        n_reset;
  logic        kill;
  logic        load;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] result;
  logic        IV;
  logic        ready;

  int errors = 0;
  int checks = 0;

  airi5c_float_cmp_unit dut (
    .clk     (clk),
    .n_reset (n_reset),
    .kill    (kill),
    .load    (load),
    .op      (op),
    .a       (a),
    .b       (b),
    .result  (result),
    .IV      (IV),
    .ready   (ready)
  );

  always #5 clk = ~clk;

  // Reference model helpers working on values rather than bit tricks.
  function automatic bit isNan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  function automatic bit isSnan(input logic [31:0] x);
    return isNan(x) && !x[22];
  endfunction

  // Signed ordering key: magnitude with the sign applied, so +0 and -0 meet.
  function automatic longint keyOf(input logic [31:0] x);
    longint mag;
    mag = longint'(x[30:0]);
    return x[31] ? -mag : mag;
  endfunction

  task automatic refModel(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          output logic [31:0] r, output logic v);
    bit anyNan, anySnan;
    longint kx, ky;
    anyNan  = isNan(x) || isNan(y);
    anySnan = isSnan(x) || isSnan(y);
    kx = keyOf(x);
    ky = keyOf(y);
    r = 32'd0;
    v = 1'b0;
    case (o)
      3'd0: begin r = {31'd0, !anyNan && kx == ky}; v = anySnan; end
      3'd1: begin r = {31'd0, !anyNan && kx < ky};  v = anyNan;  end
      3'd2: begin r = {31'd0, !anyNan && kx <= ky}; v = anyNan;  end
      3'd3, 3'd4: begin
        v = anySnan;
        if (isNan(x) && isNan(y)) r = 32'h7FC00000;
        else if (isNan(x))        r = y;
        else if (isNan(y))        r = x;
        else if (kx == ky) begin
          if (x == y)             r = x;
          else if (o == 3'd3)     r = x[31] ? x : y;
          else                    r = x[31] ? y : x;
        end
        else if ((o == 3'd3) == (kx < ky)) r = x;
        else                      r = y;
      end
      default: begin r = 32'd0; v = 1'b0; end
    endcase
  endtask

  function automatic logic [31:0] genOperand(input logic [31:0] other);
    logic [31:0] x;
    case ($urandom_range(0, 9))
      0: x = 32'h00000000;
      1: x = 32'h80000000;
      2: x = {1'($urandom), 8'hFF, 23'd0};
      3: x = {1'($urandom), 8'hFF, 1'b1, 22'($urandom)};
      4: x = {1'($urandom), 8'hFF, 1'b0, 22'($urandom) | 22'd1};
      5: x = other;
      6: x = {~other[31], other[30:0]};
      7: x = {1'($urandom), 8'($urandom_range(126, 128)), 23'($urandom_range(0, 3))};
      default: x = {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
    endcase
    return x;
  endfunction

  // Issue one load, then scramble the inputs and watch six cycles from the
  // load edge; bit k of readyMask is ready in the cycle after edge N+k.
  task automatic applyStimulus(input logic [2:0] opIn, input logic [31:0] aIn, input logic [31:0] bIn,
                               output int readyMask, output logic [31:0] res, output logic ivOut);
    @(negedge clk);
    op = opIn; a = aIn; b = bIn; load = 1'b1;
    @(posedge clk);
    @(negedge clk);
    load = 1'b0; a = $urandom; b = $urandom; op = 3'($urandom);
    readyMask = 0; res = 32'd0; ivOut = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      if (ready) readyMask |= (1 << k);
      if (k == 2) begin res = result; ivOut = IV; end
    end
  endtask

  task automatic countReady(input int cycles, output int seen);
    seen = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (ready) seen++;
    end
  endtask

  task automatic test_reset;
    n_reset = 1'b0; kill = 1'b0; load = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
    #2;
    checks++; if (result !== 32'd0) begin errors++; $display("[TB] FAIL reset_result: got %h expected 00000000", result); end
    checks++; if (IV !== 1'b0) begin errors++; $display("[TB] FAIL reset_iv: got %b expected 0", IV); end
    checks++; if (ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 0", ready); end
    repeat (3) @(negedge clk);
    n_reset = 1'b1;
  endtask

  task automatic test_directed;
    logic [2:0]  vOp [8] = '{3'd1, 3'd0, 3'd3, 3'd4, 3'd2, 3'd0, 3'd4, 3'd3};
    logic [31:0] vA  [8] = '{32'hBF800000, 32'h80000000, 32'h80000000, 32'h80000000,
                             32'h7FC00000, 32'h7FC00000, 32'h7F800001, 32'h7FC00000};
    logic [31:0] vB  [8] = '{32'h3F800000, 32'h00000000, 32'h00000000, 32'h00000000,
                             32'h3F800000, 32'h3F800000, 32'h40000000, 32'hFFC00000};
    logic [31:0] vR  [8] = '{32'h1, 32'h1, 32'h80000000, 32'h00000000,
                             32'h0, 32'h0, 32'h40000000, 32'h7FC00000};
    logic        vV  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    int mask; logic [31:0] res; logic v;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vOp[i], vA[i], vB[i], mask, res, v);
      checks++; if (mask !== 4) begin errors++; $display("[TB] FAIL directed%0d_ready_timing: got mask %0h expected 4", i, mask); end
      checks++; if (res !== vR[i]) begin errors++; $display("[TB] FAIL directed%0d_result: got %h expected %h", i, res, vR[i]); end
      checks++; if (v !== vV[i]) begin errors++; $display("[TB] FAIL directed%0d_iv: got %b expected %b", i, v, vV[i]); end
    end
  endtask

  task automatic test_random;
    int mask; logic [31:0] res, expR, x, y; logic v, expV; logic [2:0] o;
    for (int i = 0; i < 80; i++) begin
      o = 3'($urandom_range(0, 7));
      if (o > 3'd4 && $urandom_range(0, 2) != 0) o = 3'($urandom_range(0, 4));
      x = genOperand($urandom);
      y = genOperand(x);
      refModel(o, x, y, expR, expV);
      applyStimulus(o, x, y, mask, res, v);
      checks++; if (mask !== 4) begin errors++; $display("[TB] FAIL random%0d_ready_timing: got mask %0h expected 4", i, mask); end
      checks++; if (res !== expR) begin errors++; $display("[TB] FAIL random%0d_result op=%0d a=%h b=%h: got %h expected %h", i, o, x, y, res, expR); end
      checks++; if (v !== expV) begin errors++; $display("[TB] FAIL random%0d_iv op=%0d a=%h b=%h: got %b expected %b", i, o, x, y, v, expV); end
    end
  endtask

  // A second load arriving during DONE must not disturb the first completion.
  task automatic test_back_to_back;
    logic [31:0] r1, r2; logic v1, v2;
    refModel(3'd4, 32'hC0400000, 32'h3F000000, r1, v1);
    refModel(3'd2, 32'h41200000, 32'h41200000, r2, v2);
    @(negedge clk);
    op = 3'd4; a = 32'hC0400000; b = 32'h3F000000; load = 1'b1;
    @(posedge clk);
    @(negedge clk);
    load = 1'b0; a = $urandom; b = $urandom;
    @(negedge clk);
    op = 3'd2; a = 32'h41200000; b = 32'h41200000; load = 1'b1;
    @(posedge clk);
    @(negedge clk);
    load = 1'b0; a = $urandom; b = $urandom; op = 3'($urandom);
    checks++; if (ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_first_ready: got %b expected 1", ready); end
    checks++; if (result !== r1) begin errors++; $display("[TB] FAIL b2b_first_result: got %h expected %h", result, r1); end
    @(negedge clk);
    checks++; if (ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b_gap_ready: got %b expected 0", ready); end
    @(negedge clk);
    checks++; if (ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_second_ready: got %b expected 1", ready); end
    checks++; if (result !== r2) begin errors++; $display("[TB] FAIL b2b_second_result: got %h expected %h", result, r2); end
    checks++; if (IV !== v2) begin errors++; $display("[TB] FAIL b2b_second_iv: got %b expected %b", IV, v2); end
    @(negedge clk);
    checks++; if (ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b_after_ready: got %b expected 0", ready); end
  endtask

  task automatic test_kill;
    int mask, seen; logic [31:0] res; logic v;
    applyStimulus(3'd1, 32'hBF800000, 32'h3F800000, mask, res, v);
    checks++; if (res !== 32'h1) begin errors++; $display("[TB] FAIL kill_setup_result: got %h expected 00000001", res); end
    // kill while in EXEC
    @(negedge clk);
    op = 3'd0; a = 32'h3F800000; b = 32'h40000000; load = 1'b1;
    @(posedge clk);
    @(negedge clk);
    load = 1'b0; kill = 1'b1;
    @(posedge clk);
    @(negedge clk);
    kill = 1'b0;
    countReady(5, seen);
    checks++; if (seen !== 0) begin errors++; $display("[TB] FAIL kill_exec_ready: got %0d pulses expected 0", seen); end
    checks++; if (result !== 32'h1) begin errors++; $display("[TB] FAIL kill_exec_result: got %h expected 00000001", result); end
    // kill together with load
    @(negedge clk);
    op = 3'd0; a = 32'h3F800000; b = 32'h40000000; load = 1'b1; kill = 1'b1;
    @(posedge clk);
    @(negedge clk);
    load = 1'b0; kill = 1'b0;
    countReady(5, seen);
    checks++; if (seen !== 0) begin errors++; $display("[TB] FAIL kill_load_ready: got %0d pulses expected 0", seen); end
    checks++; if (result !== 32'h1) begin errors++; $display("[TB] FAIL kill_load_result: got %h expected 00000001", result); end
    // kill while in DONE
    @(negedge clk);
    op = 3'd0; a = 32'h3F800000; b = 32'h40000000; load = 1'b1;
    @(posedge clk);
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    kill = 1'b1;
    @(posedge clk);
    @(negedge clk);
    kill = 1'b0;
    checks++; if (ready !== 1'b0) begin errors++; $display("[TB] FAIL kill_done_ready: got %b expected 0", ready); end
    countReady(4, seen);
    checks++; if (seen !== 0) begin errors++; $display("[TB] FAIL kill_done_late_ready: got %0d pulses expected 0", seen); end
    checks++; if (result !== 32'h1) begin errors++; $display("[TB] FAIL kill_done_result: got %h expected 00000001", result); end
    // the unit is usable again
    applyStimulus(3'd0, 32'h3F800000, 32'h40000000, mask, res, v);
    checks++; if (mask !== 4) begin errors++; $display("[TB] FAIL kill_recover_timing: got mask %0h expected 4", mask); end
    checks++; if (res !== 32'h0) begin errors++; $display("[TB] FAIL kill_recover_result: got %h expected 00000000", res); end
  endtask

  task automatic test_async_reset;
    int mask, seen; logic [31:0] res; logic v;
    applyStimulus(3'd4, 32'h7F800001, 32'h40000000, mask, res, v);
    checks++; if (res !== 32'h40000000 || v !== 1'b1) begin errors++; $display("[TB] FAIL areset_setup: got %h/%b expected 40000000/1", res, v); end
    @(negedge clk);
    op = 3'd1; a = 32'hBF800000; b = 32'h3F800000; load = 1'b1;
    @(posedge clk);
    @(negedge clk);
    load = 1'b0;
    #2 n_reset = 1'b0;
    #1;
    checks++; if (result !== 32'd0) begin errors++; $display("[TB] FAIL areset_result: got %h expected 00000000", result); end
    checks++; if (IV !== 1'b0) begin errors++; $display("[TB] FAIL areset_iv: got %b expected 0", IV); end
    checks++; if (ready !== 1'b0) begin errors++; $display("[TB] FAIL areset_ready: got %b expected 0", ready); end
    @(negedge clk);
    n_reset = 1'b1;
    countReady(6, seen);
    checks++; if (seen !== 0) begin errors++; $display("[TB] FAIL areset_release_ready: got %0d pulses expected 0", seen); end
    checks++; if (result !== 32'd0) begin errors++; $display("[TB] FAIL areset_release_result: got %h expected 00000000", result); end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_random;
    test_back_to_back;
    test_kill;
    test_async_reset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
